dbus_ctrl: RTL and testbench
============================

# dbus_ctrl

Data-bus controller between the LSU's DBus interface and the data memory/peripheral bus. It turns the LSU's combinational, lane-0-aligned load/store request into a registered request/acknowledge transaction. It performs byte-lane alignment and misalignment detection, and drives `dbus_wait`/`dbus_err` back to the LSU. Bus timeouts are converted into errors.

## Interface
- `TIMEOUT`, 255: max cycles in BUSY without `mem_ack` before abort; 0 disables the timeout.
- `clk` input 1: core clock.
- `rst_n` input 1: reset; **one clock; reset is asynchronous and active-low**.
- `dbus_rd_en` input 1: LSU load request.
- `dbus_wr_en` input 1: LSU store request.
- `dbus_addr` input 32: byte address.
- `dbus_wr_data` input 32: store data, valid bytes in lane 0 upward.
- `dbus_wr_strobe` input 4: `4'h1`/`4'h3`/`4'hF` = byte/half/word access size (loads included).
- `dbus_rd_data` output 32: load data shifted down to lane 0.
- `dbus_wait` output 1: LSU must hold its request stable; core stalls.
- `dbus_err` output 1: misalignment, bus error or timeout; no register write.
- `mem_req` output 1: transaction request, registered.
- `mem_we` output 1: 1 = write.
- `mem_addr` output 32: word address, `{addr[31:2],2'b00}`.
- `mem_wr_data` output 32: lane-shifted store data.
- `mem_strobe` output 4: lane-shifted byte enables; 0 for reads.
- `mem_ack` input 1: transaction complete; read data valid this cycle.
- `mem_err` input 1: qualified by `mem_ack`; bus error.
- `mem_rd_data` input 32: read data.

## Operation
- FSM states `IDLE`, `BUSY`, `DONE`.
- Offset `off = dbus_addr[1:0]`.
- Misaligned cases:
  - half (`strobe 4'h3`) with `off[0]=1`;
  - word (`4'hF`) with `off != 0`;
  - `rd_en & wr_en` together.
- `IDLE`, request present and misaligned:
  - `dbus_err=1` and `dbus_wait=0` combinationally, same cycle;
  - no bus transaction; stay `IDLE`.
- `IDLE`, aligned request:
  - `dbus_wait=1` combinationally;
  - latch `mem_we`, `mem_addr`, `off`, `mem_wr_data = dbus_wr_data << 8*off`, `mem_strobe = dbus_wr_strobe << off` (writes only);
  - set `mem_req`; go to `BUSY`; clear the timeout counter.
- `BUSY`:
  - `dbus_wait=1`; `mem_*` outputs held stable;
  - on `mem_ack`: drop `mem_req`, latch `mem_rd_data` and `err = mem_err`, go to `DONE`;
  - else, when the counter reaches `TIMEOUT` (if nonzero): drop `mem_req`, latch `err=1`, go to `DONE`;
  - else increment the counter.
- `DONE`:
  - `dbus_wait=0`; `dbus_err = err`;
  - `dbus_rd_data = latched >> 8*off` (upper bytes unmasked; the LSU extends them);
  - always return to `IDLE`. A request seen in `DONE` is the completing one and is not restarted.
- `dbus_rd_data` is 0 outside `DONE`.
- `dbus_err` is 0 outside `DONE` and the misaligned-`IDLE` case.
- Counter width: `$clog2(TIMEOUT+1)`; saturates and does not wrap.

## Timing
- Reset values: state `IDLE`; `mem_req`, `mem_we`, `mem_strobe` = 0; `mem_addr`, `mem_wr_data`, latched data, counter, `err` = 0.
- Combinational outputs at reset: `dbus_wait=0` and `dbus_err=0` unless a misaligned request is present.
- Request accepted at cycle N. `mem_req` is high from N+1.
- `mem_ack` sampled at cycle N+k (k≥1); `DONE` at N+k+1.
- Minimum transaction: 3 cycles with wait high for 2.
- A new request may be accepted the cycle after `DONE`.
- `mem_req` stays high until the cycle `mem_ack` is sampled and is low the following cycle. No new `mem_req` is issued before `DONE`.
- `mem_ack` while not `BUSY` is ignored.
- `mem_ack` in the same cycle the timeout is reached: the ack wins.
- Reset mid-transaction: asynchronous return to `IDLE`; `mem_req` drops immediately; the in-flight transaction is abandoned.

## Structure
- Package `lexington` holds `dbus_state_t` (`IDLE`/`BUSY`/`DONE`) and `DBUS_TIMEOUT_DEFAULT`.
- One combinational sub-module, `dbus_align`:
  - store data/strobe shift-up;
  - read-data shift-down;
  - misalignment check from `addr[1:0]` and strobe.
- The FSM, timeout counter and latches live in `dbus_ctrl`.

## Test plan
- **Aligned word load.** LW at `0x1000`, `mem_ack` on the first `BUSY` cycle with `mem_rd_data=0xDEADBEEF`.
  - `mem_addr=0x1000`, `mem_strobe=0`, `mem_we=0`;
  - `DONE` on cycle 3 with `dbus_rd_data=0xDEADBEEF`, `dbus_wait` high for exactly 2 cycles, `dbus_err=0`.
- **Unaligned byte store.** SB at `0x2003`, data `0x000000AB`.
  - `mem_addr=0x2000`, `mem_wr_data=0xAB000000`, `mem_strobe=4'b1000`, `mem_we=1`.
- **Half load at offset 2.** LH at `0x3002`, `mem_rd_data=0x8001_1234`, ack delayed 5 cycles.
  - `mem_req` and `mem_addr` stable for all 5 cycles;
  - `dbus_rd_data` low half = `0x8001`;
  - wait high for 6 cycles.
- **Misaligned access.** LH at `0x1001`, then SW at `0x1002`.
  - `dbus_err=1` and `dbus_wait=0` in the same cycle for each;
  - `mem_req` never asserts.
- **Bus errors.**
  - `TIMEOUT=4` with no ack: abort after 4 `BUSY` cycles, `dbus_err=1` in `DONE`, `mem_req` low.
  - `mem_ack` with `mem_err=1`: `dbus_err=1` in `DONE`.
  - Ack and timeout in the same cycle: no error.
- **Reset mid-transaction.** Deassert `rst_n` in `BUSY`.
  - `mem_req` drops asynchronously; state `IDLE`.
  - After release, a fresh LW completes normally.

Source files
------------

// File: rtl/dbus_ctrl_pkg.sv
// Shared types and defaults for the data-bus controller.
// The FSM state type is exported so that the state can be observed from outside the block.
package lexington;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dbus_state_t;

    localparam int DBUS_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dbus_ctrl_align.sv
// Byte-lane steering between the LSU's lane-0 view and the word-aligned memory bus.
// Also flags accesses that cannot be expressed as a single aligned word transaction.
module dbus_align (
    input  logic [1:0]  off,
    input  logic [3:0]  strobe,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rd_raw,
    output logic [31:0] wr_data_sh,
    output logic [3:0]  strobe_sh,
    output logic [31:0] rd_data_sh,
    output logic        misaligned
);

    always_comb begin
        wr_data_sh = wr_data << {off, 3'b000};
        strobe_sh  = strobe << off;
        rd_data_sh = rd_raw >> {rd_off, 3'b000};
        // Bytes are always aligned; a simultaneous load and store is treated as malformed too.
        misaligned = ((strobe == 4'h3) && off[0])
                   || ((strobe == 4'hF) && (off != 2'b00))
                   || (rd_en && wr_en);
    end

endmodule

// File: rtl/dbus_ctrl.sv
// Registered request/acknowledge front end for the LSU data bus.
// Handshake: the LSU holds its request stable while dbus_wait is high; the bus side holds mem_req and mem_* stable until mem_ack.
module dbus_ctrl
    import lexington::*;
#(
    parameter int TIMEOUT = DBUS_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbus_rd_en,
    input  logic        dbus_wr_en,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wr_data,
    input  logic [3:0]  dbus_wr_strobe,
    output logic [31:0] dbus_rd_data,
    output logic        dbus_wait,
    output logic        dbus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_strobe,
    input  logic        mem_ack,
    input  logic        mem_err,
    input  logic [31:0] mem_rd_data,
    output dbus_state_t state
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    dbus_state_t   next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    off_q;
    logic [31:0]   rd_q;
    logic          err_q;
    logic          req_valid;
    logic          misaligned;
    logic          accept;
    logic          timeout_hit;
    logic [31:0]   wr_data_sh;
    logic [3:0]    strobe_sh;
    logic [31:0]   rd_data_sh;

    dbus_align u_align (
        .off        (dbus_addr[1:0]),
        .strobe     (dbus_wr_strobe),
        .rd_en      (dbus_rd_en),
        .wr_en      (dbus_wr_en),
        .wr_data    (dbus_wr_data),
        .rd_off     (off_q),
        .rd_raw     (rd_q),
        .wr_data_sh (wr_data_sh),
        .strobe_sh  (strobe_sh),
        .rd_data_sh (rd_data_sh),
        .misaligned (misaligned)
    );

    assign req_valid   = dbus_rd_en | dbus_wr_en;
    assign accept      = (state == IDLE) && req_valid && !misaligned;
    // Saturating increment; the timeout fires when the incremented count reaches TIMEOUT.
    assign cnt_inc     = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

    always_comb begin
        next_state   = state;
        dbus_wait    = 1'b0;
        dbus_err     = 1'b0;
        dbus_rd_data = 32'h0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        dbus_err = 1'b1;
                    end else begin
                        dbus_wait  = 1'b1;
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                dbus_wait = 1'b1;
                if (mem_ack || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                dbus_err     = err_q;
                dbus_rd_data = rd_data_sh;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wr_data <= 32'h0;
            mem_strobe  <= 4'h0;
            off_q       <= 2'b00;
            rd_q        <= 32'h0;
            err_q       <= 1'b0;
            cnt         <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                mem_req  <= 1'b1;
                mem_we   <= dbus_wr_en;
                mem_addr <= {dbus_addr[31:2], 2'b00};
                off_q    <= dbus_addr[1:0];
                err_q    <= 1'b0;
                cnt      <= '0;
                if (dbus_wr_en) begin
                    mem_wr_data <= wr_data_sh;
                    mem_strobe  <= strobe_sh;
                end else begin
                    mem_strobe  <= 4'h0;
                end
            end else if (state == BUSY) begin
                // An ack arriving on the timeout cycle takes priority over the abort.
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    rd_q    <= mem_rd_data;
                    err_q   <= mem_err;
                end else if (timeout_hit) begin
                    mem_req <= 1'b0;
                    err_q   <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: a default-timeout instance for the main flows and a TIMEOUT=4 instance for abort cases.
module tb_dbus_ctrl;
    import lexington::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wr_data = 32'h0;
    logic [3:0]  strobe = 4'h0;
    logic        ack = 1'b0;
    logic        merr = 1'b0;
    logic [31:0] mrdata = 32'h0;
    logic        to_rd_en = 1'b0;
    logic        to_ack = 1'b0;

    logic [31:0] rd_data, to_rd_data;
    logic        dwait, derr, to_wait, to_err;
    logic        mem_req, mem_we, to_req, to_we;
    logic [31:0] mem_addr, mem_wr_data, to_addr, to_wr_data;
    logic [3:0]  mem_strobe, to_strobe;
    dbus_state_t st, to_st;

    int n_vec = 0;
    int n_err = 0;
    int waits;

    always #5 clk = ~clk;

    dbus_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .dbus_rd_en(rd_en), .dbus_wr_en(wr_en),
        .dbus_addr(addr), .dbus_wr_data(wr_data), .dbus_wr_strobe(strobe),
        .dbus_rd_data(rd_data), .dbus_wait(dwait), .dbus_err(derr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_strobe(mem_strobe),
        .mem_ack(ack), .mem_err(merr), .mem_rd_data(mrdata), .state(st)
    );

    dbus_ctrl #(.TIMEOUT(4)) u_to (
        .clk(clk), .rst_n(rst_n), .dbus_rd_en(to_rd_en), .dbus_wr_en(1'b0),
        .dbus_addr(addr), .dbus_wr_data(wr_data), .dbus_wr_strobe(strobe),
        .dbus_rd_data(to_rd_data), .dbus_wait(to_wait), .dbus_err(to_err),
        .mem_req(to_req), .mem_we(to_we), .mem_addr(to_addr),
        .mem_wr_data(to_wr_data), .mem_strobe(to_strobe),
        .mem_ack(to_ack), .mem_err(merr), .mem_rd_data(mrdata), .state(to_st)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (st !== IDLE || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_strobe !== 4'h0) begin
            n_err++;
            $display("FAIL reset_ctrl: state=%0d req=%b we=%b strobe=%h, want 0/0/0/0", st, mem_req, mem_we, mem_strobe);
        end
        n_vec++;
        if (mem_addr !== 32'h0 || mem_wr_data !== 32'h0 || rd_data !== 32'h0 || dwait !== 1'b0 || derr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h wait=%b err=%b, want all 0", mem_addr, mem_wr_data, rd_data, dwait, derr);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_aligned_load();
        step();
        rd_en = 1'b1; addr = 32'h0000_1000; strobe = 4'hF; waits = 0;
        @(negedge clk);
        if (dwait) waits++;
        step();
        ack = 1'b1; mrdata = 32'hDEAD_BEEF;
        @(negedge clk);
        if (dwait) waits++;
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_strobe !== 4'h0 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL lw_bus: req=%b addr=%h strobe=%h we=%b, want 1/00001000/0/0", mem_req, mem_addr, mem_strobe, mem_we);
        end
        step();
        ack = 1'b0;
        @(negedge clk);
        if (dwait) waits++;
        n_vec++;
        if (st !== DONE || rd_data !== 32'hDEAD_BEEF || derr !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL lw_done: state=%0d rdata=%h err=%b req=%b, want 2/deadbeef/0/0", st, rd_data, derr, mem_req);
        end
        n_vec++;
        if (waits !== 2) begin
            n_err++;
            $display("FAIL lw_wait_cycles: got %0d want 2", waits);
        end
        // Back-to-back: next request is taken the cycle after DONE.
        step();
        addr = 32'h0000_1004;
        @(negedge clk);
        n_vec++;
        if (st !== IDLE || dwait !== 1'b1 || rd_data !== 32'h0) begin
            n_err++;
            $display("FAIL b2b_accept: state=%0d wait=%b rdata=%h, want 0/1/0", st, dwait, rd_data);
        end
        step();
        ack = 1'b1; mrdata = 32'h0BAD_F00D;
        @(negedge clk);
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1004) begin
            n_err++;
            $display("FAIL b2b_bus: req=%b addr=%h, want 1/00001004", mem_req, mem_addr);
        end
        step();
        ack = 1'b0;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_byte_store();
        step();
        wr_en = 1'b1; addr = 32'h0000_2003; wr_data = 32'h0000_00AB; strobe = 4'h1;
        @(negedge clk);
        step();
        ack = 1'b1;
        @(negedge clk);
        n_vec++;
        if (mem_addr !== 32'h0000_2000 || mem_wr_data !== 32'hAB00_0000 || mem_strobe !== 4'b1000 || mem_we !== 1'b1) begin
            n_err++;
            $display("FAIL sb_bus: addr=%h wdata=%h strobe=%b we=%b, want 00002000/ab000000/1000/1", mem_addr, mem_wr_data, mem_strobe, mem_we);
        end
        step();
        ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (st !== DONE || derr !== 1'b0) begin
            n_err++;
            $display("FAIL sb_done: state=%0d err=%b, want 2/0", st, derr);
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_half_load_delayed();
        step();
        rd_en = 1'b1; addr = 32'h0000_3002; strobe = 4'h3; mrdata = 32'h8001_1234; waits = 0;
        @(negedge clk);
        if (dwait) waits++;
        for (int i = 1; i <= 5; i++) begin
            step();
            ack = (i == 5);
            @(negedge clk);
            if (dwait) waits++;
            n_vec++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000 || st !== BUSY) begin
                n_err++;
                $display("FAIL lh_busy_%0d: req=%b addr=%h state=%0d, want 1/00003000/1", i, mem_req, mem_addr, st);
            end
        end
        step();
        ack = 1'b0;
        @(negedge clk);
        if (dwait) waits++;
        n_vec++;
        if (st !== DONE || rd_data[15:0] !== 16'h8001 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL lh_done: state=%0d rdata=%h req=%b, want 2/xxxx8001/0", st, rd_data, mem_req);
        end
        n_vec++;
        if (waits !== 6) begin
            n_err++;
            $display("FAIL lh_wait_cycles: got %0d want 6", waits);
        end
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_misaligned();
        logic        rds [3] = '{1'b1, 1'b0, 1'b1};
        logic        wrs [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] adrs[3] = '{32'h0000_1001, 32'h0000_1002, 32'h0000_1000};
        logic [3:0]  stbs[3] = '{4'h3, 4'hF, 4'hF};
        for (int i = 0; i < 3; i++) begin
            step();
            rd_en = rds[i]; wr_en = wrs[i]; addr = adrs[i]; strobe = stbs[i];
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                n_vec++;
                if (derr !== 1'b1 || dwait !== 1'b0 || mem_req !== 1'b0 || st !== IDLE) begin
                    n_err++;
                    $display("FAIL misaligned_%0d_%0d: err=%b wait=%b req=%b state=%0d, want 1/0/0/0", i, c, derr, dwait, mem_req, st);
                end
                if (c == 0) step();
            end
        end
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (derr !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_clear: err=%b want 0", derr);
        end
    endtask

    task automatic test_idle_ack();
        step();
        ack = 1'b1; merr = 1'b1;
        step();
        ack = 1'b0; merr = 1'b0;
        @(negedge clk);
        n_vec++;
        if (st !== IDLE || mem_req !== 1'b0 || derr !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ack: state=%0d req=%b err=%b, want 0/0/0", st, mem_req, derr);
        end
    endtask

    task automatic test_bus_error();
        step();
        rd_en = 1'b1; addr = 32'h0000_7000; strobe = 4'hF;
        step();
        ack = 1'b1; merr = 1'b1;
        step();
        ack = 1'b0; merr = 1'b0;
        @(negedge clk);
        n_vec++;
        if (st !== DONE || derr !== 1'b1 || dwait !== 1'b0) begin
            n_err++;
            $display("FAIL bus_err: state=%0d err=%b wait=%b, want 2/1/0", st, derr, dwait);
        end
        step();
        rd_en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (derr !== 1'b0 || st !== IDLE) begin
            n_err++;
            $display("FAIL bus_err_clear: err=%b state=%0d, want 0/0", derr, st);
        end
    endtask

    task automatic test_timeout(input logic late_ack);
        step();
        to_rd_en = 1'b1; addr = 32'h0000_4000; strobe = 4'hF;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            step();
            to_ack = late_ack && (i == 4);
            @(negedge clk);
            n_vec++;
            if (to_st !== BUSY || to_req !== 1'b1 || to_wait !== 1'b1) begin
                n_err++;
                $display("FAIL timeout_busy_%0d_%0d: state=%0d req=%b wait=%b, want 1/1/1", late_ack, i, to_st, to_req, to_wait);
            end
        end
        step();
        to_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (to_st !== DONE || to_err !== !late_ack || to_req !== 1'b0 || to_wait !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_done_%0d: state=%0d err=%b req=%b wait=%b, want 2/%b/0/0", late_ack, to_st, to_err, to_req, to_wait, !late_ack);
        end
        step();
        to_rd_en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (to_st !== IDLE || to_err !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_idle_%0d: state=%0d err=%b, want 0/0", late_ack, to_st, to_err);
        end
    endtask

    task automatic test_reset_mid();
        step();
        rd_en = 1'b1; addr = 32'h0000_5000; strobe = 4'hF;
        step();
        @(negedge clk);
        n_vec++;
        if (mem_req !== 1'b1 || st !== BUSY) begin
            n_err++;
            $display("FAIL rst_mid_pre: req=%b state=%0d, want 1/1", mem_req, st);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || st !== IDLE) begin
            n_err++;
            $display("FAIL rst_mid_async: req=%b state=%0d, want 0/0", mem_req, st);
        end
        step();
        rd_en = 1'b0; rst_n = 1'b1;
        step();
        rd_en = 1'b1; addr = 32'h0000_6000; strobe = 4'hF; waits = 0;
        @(negedge clk);
        if (dwait) waits++;
        step();
        ack = 1'b1; mrdata = 32'h1234_5678;
        @(negedge clk);
        if (dwait) waits++;
        step();
        ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (st !== DONE || rd_data !== 32'h1234_5678 || derr !== 1'b0 || waits !== 2) begin
            n_err++;
            $display("FAIL rst_fresh_lw: state=%0d rdata=%h err=%b waits=%0d, want 2/12345678/0/2", st, rd_data, derr, waits);
        end
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_byte_store();
        test_half_load_delayed();
        test_misaligned();
        test_idle_ack();
        test_bus_error();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
